// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, default byte width and
// the transmitter handshake contract used by both the TX and RX paths.
//
// Transmitter handshake contract:
//   - tx_start is a single-cycle pulse; tx_data is valid in that cycle and
//     is held by the producer until the next start.
//   - tx_busy rises the cycle after tx_start and stays high through the
//     stop bit. A new start may only be issued once busy has fallen.
//   - busy seen high without a preceding start (foreign or late activity)
//     blocks new starts until it falls.
package uart_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } TxArbState;

  // Increment an 8-bit counter, holding it once it reaches lim.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
    if (v >= lim) begin
      return v;
    end
    return v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin find-first: searches upward from ptr+1 and
// wraps modulo N; the pointer position itself is examined last.
module rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // First requester after the pointer wins; the previous owner loses ties.
  always_comb begin
    win  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        win[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter among NUM_REQ
// requesters. Grants are held for a packet, bounded by a burst limit and an
// inactivity timeout while waiting for the next byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned GAP_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        i_reset_n,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ-1:0]          i_req_last,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]          o_req_ready,
  output logic [NUM_REQ-1:0]          o_grant,
  output logic                        o_tx_start,
  output logic [DATA_W-1:0]           o_tx_data,
  input  logic                        i_tx_busy
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST_RST    = IW'(NUM_REQ - 1);
  localparam logic [7:0]    MAX_BURST_W = 8'(MAX_BURST);
  localparam logic [7:0]    GAP_W       = 8'(GAP_TIMEOUT);

  TxArbState     r_state;
  logic [IW-1:0] r_last;
  logic [7:0]    r_burst;
  logic [7:0]    r_gap;
  logic          r_end;

  logic [NUM_REQ-1:0] pick_win;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic [DATA_W-1:0]  req_data [NUM_REQ];
  logic               sel_valid;
  logic               sel_last;
  logic [DATA_W-1:0]  sel_data;
  logic               accept;
  logic [7:0]         burst_inc;
  logic [7:0]         gap_inc;

  // Unpack the flat data bus into one byte per requester.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_data[k] = i_req_data[k*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req (i_req_valid),
    .ptr (r_last),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

  // While granted, r_last is the owner's index, so it selects the byte lane.
  assign sel_valid = i_req_valid[r_last];
  assign sel_last  = i_req_last[r_last];
  assign sel_data  = req_data[r_last];
  assign accept    = (r_state == SEND) && sel_valid && !i_tx_busy;
  assign burst_inc = r_burst + 8'd1;
  assign gap_inc   = r_gap + 8'd1;

  // Accept strobe goes only to the owner, only in SEND with the line free.
  always_comb begin
    o_req_ready = '0;
    if (accept) begin
      o_req_ready[r_last] = 1'b1;
    end
  end

  // Arbitration FSM, counters and registered transmitter outputs.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      o_grant    <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      r_last     <= LAST_RST;
      r_burst    <= '0;
      r_gap      <= '0;
      r_end      <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (pick_any) begin
            o_grant <= pick_win;
            r_last  <= pick_idx;
            r_burst <= '0;
            r_gap   <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            o_tx_data  <= sel_data;
            o_tx_start <= 1'b1;
            r_burst    <= sat_inc8(r_burst, MAX_BURST_W);
            // Packet end and burst limit on the same byte release only once.
            r_end      <= sel_last || (burst_inc == MAX_BURST_W);
            r_state    <= WAIT_BUSY;
          end else begin
            r_gap <= gap_inc;
            if (gap_inc == GAP_W) begin
              o_grant <= '0;
              r_state <= IDLE;
            end
          end
        end
        WAIT_BUSY: begin
          if (i_tx_busy) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!i_tx_busy) begin
            if (r_end) begin
              o_grant <= '0;
              r_state <= IDLE;
            end else begin
              r_gap   <= '0;
              r_state <= SEND;
            end
          end
        end
        default: begin
          o_grant <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester byte queues drive
// the inputs, a simple transmitter model produces busy, and a scoreboard of
// expected (owner, byte) pairs is checked at every start pulse.
module tb_uart_tx_arbiter;

  localparam int NR       = 4;
  localparam int DW       = 8;
  localparam int MB       = 4;
  localparam int GT       = 20;
  localparam int BUSY_LEN = 10;

  logic              clk = 1'b0;
  logic              i_reset_n;
  logic [NR-1:0]     i_req_valid;
  logic [NR-1:0]     i_req_last;
  logic [NR*DW-1:0]  i_req_data;
  logic [NR-1:0]     o_req_ready;
  logic [NR-1:0]     o_grant;
  logic              o_tx_start;
  logic [DW-1:0]     o_tx_data;
  logic              i_tx_busy;

  int                n_vec = 0;
  int                n_err = 0;
  int                busy_cnt;
  logic [8:0]        rq [NR][$];
  logic [11:0]       sb [$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .DATA_W      (DW),
    .MAX_BURST   (MB),
    .GAP_TIMEOUT (GT)
  ) dut (
    .clk         (clk),
    .i_reset_n   (i_reset_n),
    .i_req_valid (i_req_valid),
    .i_req_last  (i_req_last),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_grant     (o_grant),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .i_tx_busy   (i_tx_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy rises the cycle after start for BUSY_LEN cycles.
  always @(posedge clk) begin
    if (!i_reset_n)              busy_cnt <= 0;
    else if (o_tx_start)         busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0)      busy_cnt <= busy_cnt - 1;
  end
  assign i_tx_busy = (busy_cnt != 0);

  // Scoreboard and protocol monitor.
  always @(negedge clk) begin
    logic [11:0] e;
    if (i_reset_n) begin
      if (o_tx_start) begin
        if (sb.size() == 0) begin
          check("unexpected_start", 32'(o_tx_data), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("start_owner", 32'(o_grant), 32'(e[11:8]));
          check("start_data", 32'(o_tx_data), 32'(e[7:0]));
        end
      end
      if (o_req_ready != '0) begin
        check("ready_onehot", 32'($countones(o_req_ready)), 32'd1);
        check("ready_in_grant", 32'(o_req_ready & ~o_grant), 32'd0);
      end
    end
  end

  task automatic drive_inputs();
    for (int k = 0; k < NR; k++) begin
      if (rq[k].size() > 0) begin
        i_req_valid[k] = 1'b1;
        {i_req_last[k], i_req_data[k*DW +: DW]} = rq[k][0];
      end else begin
        i_req_valid[k] = 1'b0;
        i_req_last[k]  = 1'b0;
        i_req_data[k*DW +: DW] = '0;
      end
    end
  endtask

  // Requester driver: pop a byte once its handshake completes.
  initial begin
    logic [NR-1:0] hs;
    i_req_valid = '0;
    i_req_last  = '0;
    i_req_data  = '0;
    forever begin
      @(negedge clk);
      hs = i_req_valid & o_req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (hs[k] && rq[k].size() > 0) void'(rq[k].pop_front());
      end
      drive_inputs();
    end
  end

  task automatic push(input int k, input logic [7:0] d, input logic last);
    rq[k].push_back({last, d});
  endtask

  task automatic expect_tx(input int k, input logic [7:0] d);
    sb.push_back({4'(1 << k), d});
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NR; k++) if (rq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk);
    i_reset_n = 1'b0;
    for (int k = 0; k < NR; k++) rq[k].delete();
    sb.delete();
    drive_inputs();
    @(negedge clk);
    check({tag, "_grant"}, 32'(o_grant), 32'd0);
    check({tag, "_ready"}, 32'(o_req_ready), 32'd0);
    check({tag, "_start"}, 32'(o_tx_start), 32'd0);
    check({tag, "_data"}, 32'(o_tx_data), 32'd0);
    i_reset_n = 1'b1;
  endtask

  task automatic wait_grant(input string tag, input logic [NR-1:0] g, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (o_grant === g) break;
    end
    check(tag, 32'(o_grant), 32'(g));
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && o_grant == '0 && all_empty()) break;
    end
    check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    check({tag, "_idle"}, 32'(o_grant), 32'd0);
  endtask

  task automatic wait_start(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (o_tx_start) break;
    end
    check(tag, 32'(o_tx_start), 32'd1);
  endtask

  task automatic wait_busy(input string tag, input logic lvl, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (i_tx_busy == lvl) break;
    end
    check(tag, 32'(i_tx_busy), 32'(lvl));
  endtask

  initial begin
    int cnt;
    i_reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_ready", 32'(o_req_ready), 32'd0);
    check("rst_start", 32'(o_tx_start), 32'd0);
    check("rst_data", 32'(o_tx_data), 32'd0);
    i_reset_n = 1'b1;

    // Single requester, one byte.
    push(1, 8'hA5, 1'b1);
    expect_tx(1, 8'hA5);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (i_req_valid != '0) break;
    end
    @(negedge clk);
    check("t1_grant", 32'(o_grant), 32'b0010);
    check("t1_ready", 32'(o_req_ready), 32'b0010);
    @(negedge clk);
    check("t1_start", 32'(o_tx_start), 32'd1);
    check("t1_data", 32'(o_tx_data), 32'hA5);
    wait_done("t1", 100);
    check("t1_busy_at_release", 32'(i_tx_busy), 32'd0);

    // All four valid: order 0,1,2,3,0.
    do_reset("r2");
    push(0, 8'h10, 1'b1); push(0, 8'h14, 1'b1);
    push(1, 8'h21, 1'b1); push(2, 8'h32, 1'b1); push(3, 8'h43, 1'b1);
    expect_tx(0, 8'h10); expect_tx(1, 8'h21); expect_tx(2, 8'h32);
    expect_tx(3, 8'h43); expect_tx(0, 8'h14);
    wait_done("t2", 300);

    // Packet hold: req2 three bytes while req0 waits.
    do_reset("r3");
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1);
    expect_tx(2, 8'hC0); expect_tx(2, 8'hC1); expect_tx(2, 8'hC2);
    wait_grant("t3_grant2", 4'b0100, 20);
    push(0, 8'h55, 1'b1);
    expect_tx(0, 8'h55);
    wait_done("t3", 300);

    // Burst limit: req1 streams 6 bytes, req3 cuts in after 4.
    do_reset("r4");
    for (int i = 0; i < 6; i++) push(1, 8'(8'hB0 + i), 1'b0);
    for (int i = 0; i < 4; i++) expect_tx(1, 8'(8'hB0 + i));
    wait_grant("t4_grant1", 4'b0010, 20);
    push(3, 8'h3C, 1'b1);
    expect_tx(3, 8'h3C);
    expect_tx(1, 8'hB4); expect_tx(1, 8'hB5);
    wait_done("t4", 500);

    // Timeout: req0 sends one byte without last, then goes quiet.
    do_reset("r5");
    push(0, 8'h77, 1'b0);
    expect_tx(0, 8'h77);
    wait_grant("t5_grant0", 4'b0001, 20);
    push(2, 8'h99, 1'b1);
    expect_tx(2, 8'h99);
    wait_start("t5_start", 20);
    wait_busy("t5_busy_hi", 1'b1, 20);
    wait_busy("t5_busy_lo", 1'b0, 40);
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (o_grant == '0) break;
      cnt++;
    end
    check("t5_gap_cycles", 32'(cnt), 32'(GT));
    wait_done("t5", 200);

    // Reset in WAIT_DONE, then requester 0 wins first.
    do_reset("r6");
    push(1, 8'hE1, 1'b0); push(1, 8'hE2, 1'b1);
    expect_tx(1, 8'hE1);
    wait_start("t6_start", 20);
    wait_busy("t6_busy_hi", 1'b1, 20);
    @(negedge clk);
    do_reset("t6_mid");
    push(1, 8'hF1, 1'b1); push(0, 8'hF0, 1'b1);
    expect_tx(0, 8'hF0); expect_tx(1, 8'hF1);
    wait_done("t6", 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
